// File: rtl/cpu_pkg.sv
// Shared definitions for the minimal 4-bit CPU: field widths, opcodes and the blink ROM image.
package cpu_pkg;

    localparam int unsigned DATA_W    = 4;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned OPC_W     = 4;
    localparam int unsigned IMM_W     = 4;
    localparam int unsigned INSTR_W   = OPC_W + IMM_W;
    localparam int unsigned ROM_DEPTH = 16;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD_A   = 4'b0000,
        OP_MOV_AB  = 4'b0001,
        OP_IN_A    = 4'b0010,
        OP_MOV_AI  = 4'b0011,
        OP_MOV_BA  = 4'b0100,
        OP_ADD_B   = 4'b0101,
        OP_IN_B    = 4'b0110,
        OP_MOV_BI  = 4'b0111,
        OP_OUT_B   = 4'b1001,
        OP_OUT_I   = 4'b1011,
        OP_JNC     = 4'b1110,
        OP_JMP     = 4'b1111
    } opcode_t;

    // Index 0 is the rightmost element: OUT 1 / ADD A,1 / JNC 1 / OUT 0 / ADD A,1 / JNC 4 / JMP 0.
    localparam logic [ROM_DEPTH-1:0][INSTR_W-1:0] ROM_IMAGE = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'hF0, 8'hE4, 8'h01, 8'hB0, 8'hE1, 8'h01, 8'hB1
    };

endpackage

// File: rtl/cpu_core.sv
// Single-cycle TD4-class core: PC, A, B, carry and output port, one instruction per clock.
module cpu_core
    import cpu_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [INSTR_W-1:0] i_rom_data,
    output logic [ADDR_W-1:0]  o_rom_addr,
    output logic [DATA_W-1:0]  o_out_port
);

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_c;
    logic [DATA_W-1:0] r_out_port;

    logic [ADDR_W-1:0] w_pc_next;
    logic [DATA_W-1:0] w_a_next;
    logic [DATA_W-1:0] w_b_next;
    logic              w_c_next;
    logic [DATA_W-1:0] w_out_next;
    logic [IMM_W-1:0]  w_imm;
    logic [DATA_W:0]   w_sum_a;
    logic [DATA_W:0]   w_sum_b;
    opcode_t           w_opcode;

    assign w_opcode = opcode_t'(i_rom_data[INSTR_W-1:IMM_W]);
    assign w_imm    = i_rom_data[IMM_W-1:0];
    assign w_sum_a  = {1'b0, r_a} + {1'b0, w_imm};
    assign w_sum_b  = {1'b0, r_b} + {1'b0, w_imm};

    // Decode and execute; carry is rewritten every cycle, so it defaults to zero.
    always_comb begin
        w_pc_next  = r_pc + ADDR_W'(1);
        w_a_next   = r_a;
        w_b_next   = r_b;
        w_c_next   = 1'b0;
        w_out_next = r_out_port;
        case (w_opcode)
            OP_ADD_A:  {w_c_next, w_a_next} = w_sum_a;
            OP_MOV_AB: w_a_next = r_b;
            OP_IN_A:   w_a_next = '0;
            OP_MOV_AI: w_a_next = w_imm;
            OP_MOV_BA: w_b_next = r_a;
            OP_ADD_B:  {w_c_next, w_b_next} = w_sum_b;
            OP_IN_B:   w_b_next = '0;
            OP_MOV_BI: w_b_next = w_imm;
            OP_OUT_B:  w_out_next = r_b;
            OP_OUT_I:  w_out_next = w_imm;
            OP_JNC:    if (!r_c) w_pc_next = w_imm;
            OP_JMP:    w_pc_next = w_imm;
            default:   ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= 1'b0;
            r_out_port <= '0;
        end else begin
            r_pc       <= w_pc_next;
            r_a        <= w_a_next;
            r_b        <= w_b_next;
            r_c        <= w_c_next;
            r_out_port <= w_out_next;
        end
    end

    assign o_rom_addr = r_pc;
    assign o_out_port = r_out_port;

endmodule

// File: rtl/cpu_top.sv
// FPGA top: CPU core plus the fixed blink program ROM; LED follows output port bit 0.
module cpu_top
    import cpu_pkg::*;
(
    input  logic pin_clock,
    input  logic pin_reset,
    output logic pin_led
);

    logic [ADDR_W-1:0]  w_rom_addr;
    logic [INSTR_W-1:0] w_rom_data;
    logic [DATA_W-1:0]  w_out_port;
    logic               w_unused_out_hi;

    assign w_rom_data = ROM_IMAGE[w_rom_addr];

    cpu_core u_core (
        .i_clk      (pin_clock),
        .i_rst      (pin_reset),
        .i_rom_data (w_rom_data),
        .o_rom_addr (w_rom_addr),
        .o_out_port (w_out_port)
    );

    // Upper port bits have no pin on this board but stay in the core.
    assign w_unused_out_hi = ^w_out_port[DATA_W-1:1];
    assign pin_led         = w_out_port[0];

endmodule

// File: tb/tb_cpu_top.sv
// Self-checking bench for cpu_top: blink timing, carry, mid-run reset, and a core ISA table.
module tb_cpu_top;

    logic       pin_clock = 1'b0;
    logic       pin_reset = 1'b1;
    logic       pin_led;

    logic       ut_rst = 1'b1;
    logic [7:0] ut_rom [16];
    logic [3:0] ut_addr;
    logic [7:0] ut_data;
    logic [3:0] ut_out;

    int checks = 0;
    int errors = 0;
    logic exp_q [$];

    always #5 pin_clock = ~pin_clock;

    cpu_top dut (
        .pin_clock (pin_clock),
        .pin_reset (pin_reset),
        .pin_led   (pin_led)
    );

    assign ut_data = ut_rom[ut_addr];

    cpu_core u_ut (
        .i_clk      (pin_clock),
        .i_rst      (ut_rst),
        .i_rom_data (ut_data),
        .o_rom_addr (ut_addr),
        .o_out_port (ut_out)
    );

    typedef struct {
        logic [3:0] pc;
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [3:0] out;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Blink reference: period 67, high for the first 33 edges after release.
    function automatic logic model_led(input int n);
        return ((n - 1) % 67) < 33;
    endfunction

    // Run n edges after reset release, scoreboarding the LED against the reference.
    task automatic run_edges(input int n);
        logic exp, act_prev;
        int   run_len;
        act_prev = 1'b0;
        run_len  = 0;
        for (int i = 1; i <= n; i++) begin
            exp_q.push_back(model_led(i));
            @(posedge pin_clock);
            #1;
            check("led_seq", int'(pin_led), int'(exp_q.pop_front()));
            if (i > 1 && pin_led != act_prev) begin
                check(act_prev ? "high_width" : "low_width", run_len, act_prev ? 33 : 34);
                run_len = 0;
            end
            if (i > 1 || pin_led) run_len++;
            act_prev = pin_led;
            if (i == 32) begin
                check("carry_a_wrap", int'(dut.u_core.r_a), 0);
                check("carry_set", int'(dut.u_core.r_c), 1);
            end
            if (i == 33) begin
                check("jnc_fallthru_pc", int'(dut.u_core.r_pc), 3);
                check("carry_clear", int'(dut.u_core.r_c), 0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ut_rom[i] = 8'h00;
        ut_rom[0]  = 8'h39; ut_rom[1]  = 8'h08; ut_rom[2]  = 8'h40; ut_rom[3]  = 8'h90;
        ut_rom[4]  = 8'h0F; ut_rom[5]  = 8'h85; ut_rom[6]  = 8'hE9; ut_rom[9]  = 8'h7E;
        ut_rom[10] = 8'h53; ut_rom[11] = 8'hE0; ut_rom[12] = 8'h60; ut_rom[13] = 8'hB7;
        ut_rom[14] = 8'h3C; ut_rom[15] = 8'h20;

        // Expected state after each executed instruction, in execution order.
        vecs[0]  = '{4'd1,  4'd9,  4'd0,  1'b0, 4'd0};
        vecs[1]  = '{4'd2,  4'd1,  4'd0,  1'b1, 4'd0};
        vecs[2]  = '{4'd3,  4'd1,  4'd1,  1'b0, 4'd0};
        vecs[3]  = '{4'd4,  4'd1,  4'd1,  1'b0, 4'd1};
        vecs[4]  = '{4'd5,  4'd0,  4'd1,  1'b1, 4'd1};
        vecs[5]  = '{4'd6,  4'd0,  4'd1,  1'b0, 4'd1};
        vecs[6]  = '{4'd9,  4'd0,  4'd1,  1'b0, 4'd1};
        vecs[7]  = '{4'd10, 4'd0,  4'd14, 1'b0, 4'd1};
        vecs[8]  = '{4'd11, 4'd0,  4'd1,  1'b1, 4'd1};
        vecs[9]  = '{4'd12, 4'd0,  4'd1,  1'b0, 4'd1};
        vecs[10] = '{4'd13, 4'd0,  4'd0,  1'b0, 4'd1};
        vecs[11] = '{4'd14, 4'd0,  4'd0,  1'b0, 4'd7};
        vecs[12] = '{4'd15, 4'd12, 4'd0,  1'b0, 4'd7};
        vecs[13] = '{4'd0,  4'd0,  4'd0,  1'b0, 4'd7};
        vecs[14] = '{4'd1,  4'd9,  4'd0,  1'b0, 4'd7};
        vecs[15] = '{4'd2,  4'd1,  4'd0,  1'b1, 4'd7};

        pin_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge pin_clock);
            #1;
            check("rst_led", int'(pin_led), 0);
            check("rst_pc", int'(dut.u_core.r_pc), 0);
            check("rst_a", int'(dut.u_core.r_a), 0);
            check("rst_c", int'(dut.u_core.r_c), 0);
        end
        pin_reset = 1'b0;
        run_edges(2000);

        // Restart, then hit reset at edge 50 in the middle of the second delay loop.
        pin_reset = 1'b1;
        @(posedge pin_clock);
        #1;
        pin_reset = 1'b0;
        run_edges(49);
        check("pre_rst_pc_nonzero", int'(dut.u_core.r_pc != 4'd0), 1);
        pin_reset = 1'b1;
        @(posedge pin_clock);
        #1;
        check("mid_rst_pc", int'(dut.u_core.r_pc), 0);
        check("mid_rst_a", int'(dut.u_core.r_a), 0);
        check("mid_rst_led", int'(pin_led), 0);
        pin_reset = 1'b0;
        run_edges(140);

        // ISA table against the substitute ROM.
        ut_rst = 1'b1;
        @(posedge pin_clock);
        #1;
        check("ut_rst_pc", int'(ut_addr), 0);
        ut_rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge pin_clock);
            #1;
            check($sformatf("ut%0d_pc", i), int'(ut_addr), int'(vecs[i].pc));
            check($sformatf("ut%0d_a", i), int'(u_ut.r_a), int'(vecs[i].a));
            check($sformatf("ut%0d_b", i), int'(u_ut.r_b), int'(vecs[i].b));
            check($sformatf("ut%0d_c", i), int'(u_ut.r_c), int'(vecs[i].c));
            check($sformatf("ut%0d_out", i), int'(ut_out), int'(vecs[i].out));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
